// File: rtl/ctrl_sequencer_pkg.sv
// ctrl_sequencer_pkg: FSM states, opcode/func encodings, HALT field.
// Shared by ctrl_decode and ctrl_sequencer; no ports.
package ctrl_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALTED
  } state_t;

  // IR[8:6]
  localparam logic [2:0] opLW    = 3'd0;
  localparam logic [2:0] opSW    = 3'd1;
  localparam logic [2:0] opADD   = 3'd2;
  localparam logic [2:0] opSUB   = 3'd3;
  localparam logic [2:0] opCEQ   = 3'd4;
  localparam logic [2:0] opCLT   = 3'd5;
  localparam logic [2:0] opOTYPE = 3'd6;
  localparam logic [2:0] opSEI   = 3'd7;

  // IR[2:0] of O-type words
  localparam logic [2:0] fnSHIFTL_X = 3'd0;
  localparam logic [2:0] fnSHIFTL_0 = 3'd1;
  localparam logic [2:0] fnSHIFTL_1 = 3'd2;
  localparam logic [2:0] fnSHIFTR_X = 3'd3;
  localparam logic [2:0] fnSHIFTR_0 = 3'd4;
  localparam logic [2:0] fnSHIFTR_1 = 3'd5;
  localparam logic [2:0] fnB0       = 3'd6;
  localparam logic [2:0] fnB1       = 3'd7;

  // IR[5:3] of an O-type word that halts
  localparam logic [2:0] HALT_FIELD = 3'b111;

  function automatic logic fn_is_shift(
    input logic [2:0] fn
  );
    return (fn == fnSHIFTL_X) ||
           (fn == fnSHIFTL_0) ||
           (fn == fnSHIFTL_1) ||
           (fn == fnSHIFTR_X) ||
           (fn == fnSHIFTR_0) ||
           (fn == fnSHIFTR_1);
  endfunction

endpackage

// File: rtl/ctrl_sequencer_decode.sv
// ctrl_decode: combinational instruction classifier.
// in: ir[8:0]; out: is_mem/is_store/writes_rf/is_branch/is_halt/updates_flags.
module ctrl_decode
  import ctrl_sequencer_pkg::*;
(
  input  logic [8:0] ir,
  output logic       is_mem,
  output logic       is_store,
  output logic       writes_rf,
  output logic       is_branch,
  output logic       is_halt,
  output logic       updates_flags
);

  logic [2:0] op;
  logic [2:0] fld;
  logic [2:0] fn;
  logic       otype;
  logic       is_load;
  logic       is_alu;

  assign op    = ir[8:6];
  assign fld   = ir[5:3];
  assign fn    = ir[2:0];
  assign otype = (op == opOTYPE);

  // HALT wins over whatever func bits it carries
  assign is_halt = otype && (fld == HALT_FIELD);

  assign is_branch = otype && !is_halt &&
                     ((fn == fnB0) || (fn == fnB1));

  assign is_load  = (op == opLW);
  assign is_store = (op == opSW);
  assign is_mem   = is_load || is_store;

  assign is_alu = (op == opADD) ||
                  (op == opSUB) ||
                  (op == opSEI) ||
                  (otype && !is_halt && fn_is_shift(fn));

  assign writes_rf     = is_alu || is_load;
  assign updates_flags = !(is_branch || is_halt);

endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: fetch/exec/mem/wb control FSM with PC, IR, flags.
// in: START, INST*, ALU returns, BR_TARGET, MEM_READY; out: fetch, ALU, mem, RF_WE, DONE.
module ctrl_sequencer
  import ctrl_sequencer_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       START,
  input  logic       INST_VALID,
  input  logic [8:0] INST,
  output logic       INST_REQ,
  output logic [7:0] PC,
  output logic [2:0] ALU_OP,
  output logic [2:0] ALU_FUNC,
  output logic       ALU_FLAG_IN,
  output logic       ALU_OVERFLOW_IN,
  input  logic       ALU_FLAG_OUT,
  input  logic       ALU_OVERFLOW_OUT,
  input  logic       ALU_BRANCH_EN,
  input  logic [7:0] BR_TARGET,
  output logic       MEM_REQ,
  output logic       MEM_WE,
  input  logic       MEM_READY,
  output logic       RF_WE,
  output logic       DONE
);

  state_t     state;
  state_t     state_nxt;
  logic [8:0] ir;
  logic       flag_r;
  logic       ovf_r;
  logic       br_pend;
  logic       take_br;

  logic is_mem;
  logic is_store;
  logic writes_rf;
  logic is_branch;
  logic is_halt;
  logic updates_flags;

  ctrl_decode u_decode (
    .ir            (ir),
    .is_mem        (is_mem),
    .is_store      (is_store),
    .writes_rf     (writes_rf),
    .is_branch     (is_branch),
    .is_halt       (is_halt),
    .updates_flags (updates_flags)
  );

  assign ALU_OP          = ir[8:6];
  assign ALU_FUNC        = ir[2:0];
  assign ALU_FLAG_IN     = flag_r;
  assign ALU_OVERFLOW_IN = ovf_r;

  // Branch decision: live sample while leaving EXEC,
  // the registered copy on any later exit.
  assign take_br = (state == S_EXEC) ?
                   (is_branch && ALU_BRANCH_EN) :
                   br_pend;

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (START) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (INST_VALID) state_nxt = S_EXEC;
      end
      S_EXEC: begin
        unique case (1'b1)
          is_mem:                 state_nxt = S_MEM;
          is_halt:                state_nxt = S_HALTED;
          writes_rf && !is_mem:   state_nxt = S_WB;
          default:                state_nxt = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (MEM_READY)
          state_nxt = is_store ? S_FETCH : S_WB;
      end
      S_WB: begin
        state_nxt = S_FETCH;
      end
      S_HALTED: begin
        if (START) state_nxt = S_FETCH;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so each
  // strobe is aligned with the state it belongs to.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= S_IDLE;
      PC       <= 8'h00;
      ir       <= 9'h000;
      flag_r   <= 1'b0;
      ovf_r    <= 1'b0;
      br_pend  <= 1'b0;
      INST_REQ <= 1'b0;
      MEM_REQ  <= 1'b0;
      MEM_WE   <= 1'b0;
      RF_WE    <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      state    <= state_nxt;
      INST_REQ <= (state_nxt == S_FETCH);
      MEM_REQ  <= (state_nxt == S_MEM);
      MEM_WE   <= (state_nxt == S_MEM) && is_store;
      RF_WE    <= (state_nxt == S_WB);
      DONE     <= (state_nxt == S_HALTED);

      if (state == S_FETCH) begin
        br_pend <= 1'b0;
        if (INST_VALID) ir <= INST;
      end

      if (state == S_EXEC) begin
        br_pend <= is_branch && ALU_BRANCH_EN;
        if (updates_flags) begin
          flag_r <= ALU_FLAG_OUT;
          ovf_r  <= ALU_OVERFLOW_OUT;
        end
      end

      if (state_nxt == S_FETCH) begin
        unique case (state)
          S_EXEC, S_MEM, S_WB: begin
            PC <= take_br ? BR_TARGET : PC + 8'd1;
          end
          S_HALTED: begin
            PC     <= 8'h00;
            flag_r <= 1'b0;
            ovf_r  <= 1'b0;
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: self-checking bench for ctrl_sequencer.
// Instruction-level model: per-class latency, strobes, PC and flags.
module tb_ctrl_sequencer;

  localparam int C_ALU  = 0;
  localparam int C_CMP  = 1;
  localparam int C_BR   = 2;
  localparam int C_LW   = 3;
  localparam int C_SW   = 4;
  localparam int C_HALT = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       inst_valid;
  logic [8:0] inst_w;
  logic       inst_req;
  logic [7:0] pc;
  logic [2:0] alu_op;
  logic [2:0] alu_func;
  logic       alu_flag_in;
  logic       alu_ovf_in;
  logic       alu_flag_out;
  logic       alu_ovf_out;
  logic       alu_br_en;
  logic [7:0] br_target;
  logic       mem_req;
  logic       mem_we;
  logic       mem_ready;
  logic       rf_we;
  logic       done;

  logic [20:0] outs;
  assign outs = {inst_req, mem_req, mem_we, rf_we, done,
                 alu_op, alu_func, alu_flag_in, alu_ovf_in, pc};

  int checks = 0;
  int failures = 0;

  logic [7:0] mpc;
  logic       mflag;
  logic       movf;

  ctrl_sequencer dut (
    .CLK              (clk),
    .RESET_N          (rst_n),
    .START            (start),
    .INST_VALID       (inst_valid),
    .INST             (inst_w),
    .INST_REQ         (inst_req),
    .PC               (pc),
    .ALU_OP           (alu_op),
    .ALU_FUNC         (alu_func),
    .ALU_FLAG_IN      (alu_flag_in),
    .ALU_OVERFLOW_IN  (alu_ovf_in),
    .ALU_FLAG_OUT     (alu_flag_out),
    .ALU_OVERFLOW_OUT (alu_ovf_out),
    .ALU_BRANCH_EN    (alu_br_en),
    .BR_TARGET        (br_target),
    .MEM_REQ          (mem_req),
    .MEM_WE           (mem_we),
    .MEM_READY        (mem_ready),
    .RF_WE            (rf_we),
    .DONE             (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1, "watchdog");
  end

  function automatic int iclass(input logic [8:0] w);
    logic [2:0] op;
    logic [2:0] f;
    logic [2:0] fn;
    op = w[8:6];
    f  = w[5:3];
    fn = w[2:0];
    if (op == 3'd6 && f == 3'd7) return C_HALT;
    if (op == 3'd6) return (fn >= 3'd6) ? C_BR : C_ALU;
    case (op)
      3'd0:       return C_LW;
      3'd1:       return C_SW;
      3'd4, 3'd5: return C_CMP;
      default:    return C_ALU;
    endcase
  endfunction

  function automatic logic [8:0] make_inst(input int c);
    logic [5:0] r6;
    logic [2:0] f;
    logic [2:0] fn;
    r6 = 6'($urandom);
    f  = 3'($urandom_range(0, 6));
    case (c)
      C_ALU: begin
        case ($urandom_range(0, 3))
          0: return {3'd2, r6};
          1: return {3'd3, r6};
          2: return {3'd7, r6};
          default: begin
            fn = 3'($urandom_range(0, 5));
            return {3'd6, f, fn};
          end
        endcase
      end
      C_CMP: return {($urandom_range(0, 1) == 0) ? 3'd4 : 3'd5, r6};
      C_BR: begin
        fn = ($urandom_range(0, 1) == 0) ? 3'd6 : 3'd7;
        return {3'd6, f, fn};
      end
      C_LW: return {3'd0, r6};
      C_SW: return {3'd1, r6};
      default: begin
        fn = 3'($urandom);
        return {3'd6, 3'd7, fn};
      end
    endcase
  endfunction

  task automatic kick;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mpc = 8'h00;
    mflag = 1'b0;
    movf = 1'b0;
    checks++;
    if (inst_req !== 1'b1 || done !== 1'b0 || pc !== 8'h00 ||
        alu_flag_in !== 1'b0 || alu_ovf_in !== 1'b0) begin
      failures++;
      $display("FAIL kick: req=%b done=%b pc=%h fl=%b ov=%b want 1 0 00 0 0",
               inst_req, done, pc, alu_flag_in, alu_ovf_in);
    end
  endtask

  // Runs one instruction from its FETCH cycle to the next FETCH/HALTED.
  task automatic run_inst(input logic [8:0] inst, input logic fo,
                          input logic oo, input logic ben,
                          input logic [7:0] tgt, input int fw,
                          input int mw, input bit noise);
    int cl;
    int c;
    int nrf;
    int rfc;
    int nmreq;
    int nmwe;
    int elat;
    int erfc;
    int emreq;
    bit fin;
    bit ismem;
    cl = iclass(inst);
    ismem = (cl == C_LW || cl == C_SW);
    for (int i = 0; i < fw; i++) begin
      checks++;
      if (inst_req !== 1'b1 || pc !== mpc) begin
        failures++;
        $display("FAIL fetch_wait: req=%b pc=%h want 1 %h", inst_req, pc, mpc);
      end
      inst_valid = 1'b0;
      start = noise ? 1'($urandom) : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (inst_req !== 1'b1 || pc !== mpc || done !== 1'b0) begin
      failures++;
      $display("FAIL fetch: req=%b pc=%h done=%b want 1 %h 0",
               inst_req, pc, done, mpc);
    end
    inst_valid   = 1'b1;
    inst_w       = inst;
    alu_flag_out = fo;
    alu_ovf_out  = oo;
    alu_br_en    = ben;
    br_target    = tgt;
    @(negedge clk);
    inst_valid = 1'b0;
    inst_w = 9'($urandom);
    checks++;
    if (alu_op !== inst[8:6] || alu_func !== inst[2:0]) begin
      failures++;
      $display("FAIL alu_ctl: op=%h fn=%h want %h %h",
               alu_op, alu_func, inst[8:6], inst[2:0]);
    end
    c = 2; fin = 0; nrf = 0; rfc = 0; nmreq = 0; nmwe = 0;
    for (int k = 0; k < 64 && !fin; k++) begin
      if (inst_req === 1'b1 || done === 1'b1) fin = 1;
      else begin
        if (rf_we === 1'b1) begin nrf++; rfc = c; end
        if (mem_we === 1'b1) nmwe++;
        if (mem_req === 1'b1) begin
          nmreq++;
          mem_ready = (nmreq > mw);
        end else mem_ready = 1'($urandom);
        start = noise ? 1'($urandom) : 1'b0;
        if (c >= 3) begin
          alu_flag_out = 1'($urandom);
          alu_ovf_out  = 1'($urandom);
          alu_br_en    = 1'($urandom);
          br_target    = 8'($urandom);
        end
        @(negedge clk);
        c++;
      end
    end
    start = 1'b0;
    mem_ready = 1'b0;
    checks++;
    if (!fin) begin
      failures++;
      $display("FAIL timeout: inst=%h no fetch/halt within 64 cycles", inst);
    end
    case (cl)
      C_ALU:   elat = 3;
      C_LW:    elat = 4 + mw;
      C_SW:    elat = 3 + mw;
      default: elat = 2;
    endcase
    erfc = (cl == C_ALU) ? 3 : (cl == C_LW) ? 4 + mw : 0;
    emreq = ismem ? mw + 1 : 0;
    checks++;
    if (c - 1 !== elat) begin
      failures++;
      $display("FAIL latency: inst=%h got %0d want %0d", inst, c - 1, elat);
    end
    checks++;
    if (nrf !== ((erfc != 0) ? 1 : 0) || rfc !== erfc) begin
      failures++;
      $display("FAIL rf_we: inst=%h n=%0d cyc=%0d want n=%0d cyc=%0d",
               inst, nrf, rfc, (erfc != 0) ? 1 : 0, erfc);
    end
    checks++;
    if (nmreq !== emreq || nmwe !== ((cl == C_SW) ? emreq : 0)) begin
      failures++;
      $display("FAIL mem: inst=%h req=%0d we=%0d want %0d %0d",
               inst, nmreq, nmwe, emreq, (cl == C_SW) ? emreq : 0);
    end
    if (cl != C_BR && cl != C_HALT) begin
      mflag = fo;
      movf = oo;
    end
    if (cl == C_BR && ben) mpc = tgt;
    else if (cl != C_HALT) mpc = mpc + 8'd1;
    checks++;
    if (pc !== mpc || alu_flag_in !== mflag || alu_ovf_in !== movf ||
        done !== (cl == C_HALT) || inst_req !== (cl != C_HALT)) begin
      failures++;
      $display("FAIL state: inst=%h pc=%h fl=%b ov=%b done=%b req=%b want %h %b %b %b %b",
               inst, pc, alu_flag_in, alu_ovf_in, done, inst_req,
               mpc, mflag, movf, cl == C_HALT, cl != C_HALT);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b1; inst_valid = 1'b0; inst_w = 9'h1FF;
    alu_flag_out = 1'b1; alu_ovf_out = 1'b1; alu_br_en = 1'b1;
    br_target = 8'hAA; mem_ready = 1'b1;
    #1;
    checks++;
    if (outs !== 21'h0) begin
      failures++;
      $display("FAIL reset_outs: got %h want 0", outs);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (outs !== 21'h0) begin
      failures++;
      $display("FAIL reset_hold: got %h want 0", outs);
    end
    start = 1'b0; mem_ready = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (outs !== 21'h0) begin
      failures++;
      $display("FAIL idle_after_reset: got %h want 0", outs);
    end
    mpc = 8'h00; mflag = 1'b0; movf = 1'b0;
  endtask

  task automatic test_add;
    kick();
    run_inst({3'd2, 6'h2B}, 1'b0, 1'b1, 1'b0, 8'h00, 1, 0, 0);
  endtask

  task automatic test_branch;
    run_inst({3'd4, 6'h11}, 1'b1, 1'b0, 1'b0, 8'h00, 0, 0, 0);
    run_inst({3'd6, 3'd2, 3'd7}, 1'b0, 1'b1, 1'b1, 8'h40, 0, 0, 0);
  endtask

  task automatic test_lw;
    run_inst({3'd0, 6'h05}, 1'b1, 1'b1, 1'b0, 8'h00, 0, 3, 0);
  endtask

  task automatic test_sw;
    run_inst({3'd1, 6'h09}, 1'b0, 1'b0, 1'b1, 8'h33, 0, 2, 0);
  endtask

  task automatic test_wrap_halt;
    run_inst({3'd6, 3'd0, 3'd6}, 1'b0, 1'b0, 1'b1, 8'hFF, 0, 0, 0);
    run_inst({3'd3, 6'h07}, 1'b1, 1'b1, 1'b0, 8'h00, 0, 0, 0);
    run_inst({3'd2, 6'h01}, 1'b1, 1'b1, 1'b0, 8'h00, 0, 0, 0);
    run_inst({3'd6, 3'd7, 3'd0}, 1'b0, 1'b0, 1'b1, 8'h77, 0, 0, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b1 || pc !== 8'h01 || inst_req !== 1'b0) begin
      failures++;
      $display("FAIL halted_hold: done=%b pc=%h req=%b want 1 01 0",
               done, pc, inst_req);
    end
    kick();
  endtask

  task automatic test_back_to_back;
    int r;
    int cl;
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 11);
      cl = (r < 4) ? C_ALU : (r < 6) ? C_CMP : (r < 8) ? C_BR :
           (r == 8 || r == 10) ? C_LW : (r == 9) ? C_SW : C_HALT;
      run_inst(make_inst(cl), 1'($urandom), 1'($urandom), 1'($urandom),
               8'($urandom), $urandom_range(0, 2), $urandom_range(0, 3), 1);
      if (cl == C_HALT) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
        kick();
      end
    end
  endtask

  task automatic test_reset_mid;
    int n;
    rst_n = 1'b0;
    #1;
    checks++;
    if (outs !== 21'h0) begin
      failures++;
      $display("FAIL reset_in_fetch: got %h want 0", outs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    kick();
    inst_valid = 1'b1;
    inst_w = {3'd0, 6'h15};
    @(negedge clk);
    inst_valid = 1'b0;
    n = 0;
    while (mem_req !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin
      failures++;
      $display("FAIL mem_before_reset: mem_req=%b want 1", mem_req);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (outs !== 21'h0) begin
      failures++;
      $display("FAIL reset_in_mem: got %h want 0", outs);
    end
    start = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (outs !== 21'h0) begin
        failures++;
        $display("FAIL start_in_reset: got %h want 0", outs);
      end
    end
    start = 1'b0;
    mem_ready = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (inst_req !== 1'b0 || pc !== 8'h00 || rf_we !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_mid_reset: req=%b pc=%h rf=%b want 0 00 0",
               inst_req, pc, rf_we);
    end
    kick();
    run_inst({3'd7, 6'h3C}, 1'b1, 1'b0, 1'b0, 8'h00, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_branch();
    test_lw();
    test_sw();
    test_wrap_halt();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
